// File: rtl/line_pkg.sv
// Shared definitions for the line rasteriser: state encoding, internal
// arithmetic width helper and default visible-screen limits.
package line_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_XMAX = 639;
  localparam int DEF_YMAX = 479;

  // Signed width wide enough for 2*err and the dx/dy sums without overflow.
  function automatic int ew_f(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: err_next and cur_next from the current
// error term, deltas and step directions (sx/sy given as "step negative" flags).
module bresenham_step #(
  parameter int EW = 12
) (
  input  logic signed [EW-1:0] i_err,
  input  logic signed [EW-1:0] i_dx,
  input  logic signed [EW-1:0] i_dy,
  input  logic signed [EW-1:0] i_cur_x,
  input  logic signed [EW-1:0] i_cur_y,
  input  logic                 i_sx_neg,
  input  logic                 i_sy_neg,
  output logic signed [EW-1:0] o_err_next,
  output logic signed [EW-1:0] o_cur_x_next,
  output logic signed [EW-1:0] o_cur_y_next
);

  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] ZERO = EW'(0);

  logic signed [EW-1:0] w_e2;
  logic                 w_step_x;
  logic                 w_step_y;

  // Both decisions use the same e2, so the error update is one combined sum.
  always_comb begin
    w_e2         = i_err <<< 1;
    w_step_x     = (w_e2 >= i_dy);
    w_step_y     = (w_e2 <= i_dx);
    o_err_next   = i_err + (w_step_x ? i_dy : ZERO) + (w_step_y ? i_dx : ZERO);
    o_cur_x_next = i_cur_x;
    o_cur_y_next = i_cur_y;
    if (w_step_x) begin
      o_cur_x_next = i_sx_neg ? (i_cur_x - ONE) : (i_cur_x + ONE);
    end else begin
      o_cur_x_next = i_cur_x;
    end
    if (w_step_y) begin
      o_cur_y_next = i_sy_neg ? (i_cur_y - ONE) : (i_cur_y + ONE);
    end else begin
      o_cur_y_next = i_cur_y;
    end
  end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: one command in, one pixel per cycle out on a
// stallable stream. Define LINE_CLIP_EN to suppress pixels beyond XMAX/YMAX.
module line_raster_engine
  import line_pkg::*;
#(
  parameter int XW   = 10,
  parameter int YW   = 9,
  parameter int CW   = 3,
  parameter int XMAX = DEF_XMAX,
  parameter int YMAX = DEF_YMAX
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y0,
  input  logic [YW-1:0] cmd_y1,
  input  logic [CW-1:0] cmd_colour,
  input  logic          abort,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [CW-1:0] pix_colour,
  output logic          busy,
  output logic          done
);

  localparam int EW = ew_f(XW, YW);
`ifdef LINE_CLIP_EN
  localparam logic CLIP = 1'b1;
`else
  localparam logic CLIP = 1'b0;
`endif
  localparam logic signed [EW-1:0] XMAX_E = EW'(XMAX);
  localparam logic signed [EW-1:0] YMAX_E = EW'(YMAX);

  state_t               r_state, w_state_next;
  logic signed [EW-1:0] r_x0, r_y0, r_x1, r_y1;
  logic signed [EW-1:0] r_dx, r_dy, r_err, r_cx, r_cy;
  logic                 r_sx_neg, r_sy_neg;
  logic [CW-1:0]        r_colour;
  logic                 r_pix_valid, r_cmd_ready, r_busy, r_done;

  logic signed [EW-1:0] w_err_next, w_cx_next, w_cy_next, w_dx, w_dy;
  logic                 w_accept, w_at_end, w_adv, w_step_en;
  logic                 w_vis_start, w_vis_next, w_pv_next;

  bresenham_step #(.EW(EW)) u_step (
    .i_err        (r_err),
    .i_dx         (r_dx),
    .i_dy         (r_dy),
    .i_cur_x      (r_cx),
    .i_cur_y      (r_cy),
    .i_sx_neg     (r_sx_neg),
    .i_sy_neg     (r_sy_neg),
    .o_err_next   (w_err_next),
    .o_cur_x_next (w_cx_next),
    .o_cur_y_next (w_cy_next)
  );

  assign w_accept    = r_cmd_ready && cmd_valid;
  assign w_dx        = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_dy        = (r_y1 >= r_y0) ? (r_y0 - r_y1) : (r_y1 - r_y0);
  assign w_at_end    = (r_cx == r_x1) && (r_cy == r_y1);
  // An invisible (clipped) pixel never waits for pix_ready.
  assign w_adv       = !r_pix_valid || pix_ready;
  assign w_step_en   = (r_state == S_DRAW) && !abort && w_adv && !w_at_end;
  assign w_vis_start = !CLIP || ((r_x0 <= XMAX_E) && (r_y0 <= YMAX_E));
  assign w_vis_next  = !CLIP || ((w_cx_next <= XMAX_E) && (w_cy_next <= YMAX_E));

  // Next-state and next pix_valid decision.
  always_comb begin
    w_state_next = r_state;
    w_pv_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_SETUP;
        else          w_state_next = S_IDLE;
      end
      S_SETUP: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DRAW;
          w_pv_next    = w_vis_start;
        end
      end
      S_DRAW: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (!w_adv) begin
          w_pv_next = r_pix_valid;
        end else if (w_at_end) begin
          w_state_next = S_DONE;
        end else begin
          w_pv_next = w_vis_next;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_sx_neg    <= 1'b0;
      r_sy_neg    <= 1'b0;
      r_colour    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cmd_ready <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= (w_state_next == S_DONE);
      r_pix_valid <= w_pv_next;
      if (w_accept) begin
        r_x0     <= $signed({{(EW-XW){1'b0}}, cmd_x0});
        r_y0     <= $signed({{(EW-YW){1'b0}}, cmd_y0});
        r_x1     <= $signed({{(EW-XW){1'b0}}, cmd_x1});
        r_y1     <= $signed({{(EW-YW){1'b0}}, cmd_y1});
        r_colour <= cmd_colour;
      end
      if (r_state == S_SETUP) begin
        r_dx     <= w_dx;
        r_dy     <= w_dy;
        r_err    <= w_dx + w_dy;
        r_sx_neg <= !(r_x1 > r_x0);
        r_sy_neg <= !(r_y1 > r_y0);
        r_cx     <= r_x0;
        r_cy     <= r_y0;
      end
      if (w_step_en) begin
        r_err <= w_err_next;
        r_cx  <= w_cx_next;
        r_cy  <= w_cy_next;
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_cx[XW-1:0];
  assign pix_y      = r_cy[YW-1:0];
  assign pix_colour = r_colour;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: doc/line_raster_engine.md
Name: line_raster_engine

Overview:
- Parametrised next-generation Bresenham rasteriser for mouse and shape drawing. It accepts one line command through a valid/ready handshake.
- It emits one pixel per cycle on a valid/ready pixel stream that the VGA framebuffer writer can stall.
- Generalised coordinate and colour widths, correct single-step error update, colour pass-through, abort, and optional screen clipping.

Parameters:
- XW, 10, X coordinate width (bits)
- YW, 9, Y coordinate width (bits)
- CW, 3, colour width (bits)
- XMAX, 639, largest visible X; used only when clipping is compiled in
- YMAX, 479, largest visible Y; used only when clipping is compiled in

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0, cmd_x1  in  XW  start and end X
- cmd_y0, cmd_y1  in  YW  start and end Y
- cmd_colour  in  CW  line colour
- abort  in  1  synchronous abort of the current line
- pix_valid  out  1  pix_x/pix_y/pix_colour are valid
- pix_ready  in  1  downstream accepts the pixel
- pix_x  out  XW  pixel X
- pix_y  out  YW  pixel Y
- pix_colour  out  CW  pixel colour
- busy  out  1  high in SETUP, DRAW and DONE
- done  out  1  one-cycle pulse when the line completes

Behaviour:
- Reset values: state IDLE; cmd_ready=1; pix_valid=0; pix_x=0; pix_y=0; pix_colour=0; busy=0; done=0. Reset mid-line discards the line and emits no done.
- Internal arithmetic is signed with width EW=max(XW,YW)+2. dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1 if end>start else -1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch endpoints and colour; go to SETUP.
- SETUP (1 cycle):
  - cmd_ready=0.
  - Compute dx, dy, sx, sy, err=dx+dy and cur=(x0,y0); go to DRAW.
- DRAW:
  - pix_valid=1 with pix=(cur,colour). Outputs are registered and reflect cur.
  - Hold all outputs while pix_valid&&!pix_ready.
  - On handshake at cur==end, go to DONE.
  - Otherwise, in the same cycle, with e2=2*err:
    - if e2>=dy then x+=sx and err gets +dy;
    - if e2<=dx then y+=sy and err gets +dx.
    - When both conditions hold, err_next=err+dy+dx. This is a single combined assignment; one update must not overwrite the other.
- DONE: done=1 for exactly one cycle, pix_valid=0; go to IDLE, where cmd_ready=1 the following cycle.
- Latency:
  - Command accepted at cycle N, first pix_valid at N+2.
  - With pix_ready held high, pixel count is max(|dx|,|dy|)+1 on consecutive cycles, then done one cycle after the last handshake.
- Degenerate cases:
  - x0==x1 and y0==y1: exactly one pixel, then done.
  - Horizontal, vertical and 45-degree lines have no gaps and no repeated pixels.
- Coordinates never wrap: cur stays within the span [min, max] of the endpoints.
- abort:
  - Has effect in SETUP and DRAW; it takes priority over a pixel handshake in the same cycle.
  - State goes to IDLE next cycle, pix_valid=0, no done pulse.
  - abort in IDLE is ignored.
- cmd_valid while busy is ignored; the command is not lost because cmd_ready=0.

Optional Feature:
- LINE_CLIP_EN defined:
  - Pixels with x>XMAX or y>YMAX are stepped over internally at one per cycle with pix_valid=0; they need no pix_ready.
  - done still fires after the end point is processed, visible or not.
  - A line that is entirely off-screen produces zero pixels and then done.
- LINE_CLIP_EN undefined: every pixel is emitted; XMAX/YMAX are unused.

Decomposition:
- Package line_pkg: state encoding (IDLE, SETUP, DRAW, DONE), EW width function, default XMAX/YMAX constants.
- One sub-module, bresenham_step (combinational): inputs err/dx/dy/sx/sy/cur; outputs err_next/cur_next. Reused by future circle and rectangle engines.

Test Plan:
- (0,0)->(5,2), pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); first pix_valid 2 cycles after accept; done 1 cycle after last pixel.
- (10,10)->(10,10) -> single pixel (10,10), then done; cmd_ready back high the next cycle.
- (7,3)->(3,7), pix_ready toggling 1,0,0,1 -> pixels (7,3),(6,4),(5,5),(4,6),(3,7); outputs stable across stalls; no duplicates.
- (0,0)->(100,0), abort on 3rd pixel cycle -> exactly 2 pixels handshaken; no done; IDLE next cycle; a new command is accepted normally.
- LINE_CLIP_EN, (636,0)->(643,0) -> pixels x=636..639 only; done after x=643 is processed; (700,500)->(710,500) -> zero pixels, then done.
- resetn low during DRAW -> next cycle pix_valid=0, busy=0, cmd_ready=1; no done.
